// File: rtl/pointer_sequencer.sv
// Job-level sequencer ahead of pointer_array: splits a job into groups of N_UNITS
// channels, issues K*K back-pressured steps per group, then drains and signals completion.
module pointer_sequencer #(
  parameter int N_UNITS      = 4,
  parameter int DRAIN_CYCLES = 2   // must be >= 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        cfg_base,
  input  logic [7:0]         cfg_ksize,
  input  logic [7:0]         cfg_n_out,
  input  logic               ready,
  output logic               step,
  output logic [15:0]        start_addr,
  output logic [7:0]         kernel_size,
  output logic [N_UNITS-1:0] active_units,
  output logic               grp_load,
  output logic               grp_done,
  output logic               busy,
  output logic               done
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [7:0] N_U8 = 8'(N_UNITS);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0]        taps_reg;
  logic [15:0]        stride_reg;
  logic [7:0]         rem_reg;        // channels left, including the current group
  logic [15:0]        tap_cnt_reg;
  logic [DW-1:0]      drain_cnt_reg;
  logic [15:0]        start_addr_reg;
  logic [7:0]         kernel_size_reg;
  logic [N_UNITS-1:0] active_units_reg;

  logic [15:0]        cfg_taps;
  logic [15:0]        cfg_stride;
  logic               zero_job;
  logic [7:0]         rem_after;
  logic               more_groups;
  logic               last_tap;
  logic               drain_last;
  logic [N_UNITS-1:0] mask_cfg;
  logic [N_UNITS-1:0] mask_rem;

  assign cfg_taps    = 16'(cfg_ksize) * 16'(cfg_ksize);
  assign cfg_stride  = 16'(N_UNITS) * cfg_taps;
  assign zero_job    = (cfg_taps == 16'd0) || (cfg_n_out == 8'd0);
  assign rem_after   = rem_reg - N_U8;
  assign more_groups = rem_reg > N_U8;
  assign last_tap    = tap_cnt_reg == (taps_reg - 16'd1);
  assign drain_last  = drain_cnt_reg == DRAIN_LAST;

  // Unit gi is enabled when more than gi channels remain in the group.
  generate
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_mask
      assign mask_cfg[gi] = cfg_n_out > 8'(gi);
      assign mask_rem[gi] = rem_after > 8'(gi);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    step       = 1'b0;
    grp_load   = 1'b0;
    grp_done   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = zero_job ? DONE : LOAD;
      end
      LOAD: begin
        grp_load   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        step = ready;
        if (ready && last_tap) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_last) begin
          grp_done   = 1'b1;
          state_next = more_groups ? LOAD : DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = state_reg != IDLE;
  assign start_addr   = start_addr_reg;
  assign kernel_size  = kernel_size_reg;
  assign active_units = active_units_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= IDLE;
      taps_reg         <= '0;
      stride_reg       <= '0;
      rem_reg          <= '0;
      tap_cnt_reg      <= '0;
      drain_cnt_reg    <= '0;
      start_addr_reg   <= '0;
      kernel_size_reg  <= '0;
      active_units_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Group-0 parameters are registered on the way into LOAD so they are valid with grp_load.
      if (state_reg == IDLE && start) begin
        taps_reg         <= cfg_taps;
        stride_reg       <= cfg_stride;
        rem_reg          <= cfg_n_out;
        kernel_size_reg  <= cfg_ksize;
        start_addr_reg   <= cfg_base;
        active_units_reg <= zero_job ? '0 : mask_cfg;
        tap_cnt_reg      <= '0;
        drain_cnt_reg    <= '0;
      end
      if (state_reg == RUN && ready) begin
        tap_cnt_reg <= last_tap ? 16'd0 : tap_cnt_reg + 16'd1;
      end
      if (state_reg == DRAIN) begin
        drain_cnt_reg <= drain_last ? '0 : drain_cnt_reg + DW'(1);
        if (drain_last && more_groups) begin
          rem_reg          <= rem_after;
          start_addr_reg   <= start_addr_reg + stride_reg;
          active_units_reg <= mask_rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_pointer_sequencer.sv
// Directed bench for pointer_sequencer: hand-computed job traces checked with
// immediate assertions; inputs driven and outputs sampled on the falling edge.
module tb_pointer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [7:0]  cfg_ksize = '0;
  logic [7:0]  cfg_n_out = '0;
  logic        ready = 1'b0;
  logic        step;
  logic [15:0] start_addr;
  logic [7:0]  kernel_size;
  logic [3:0]  active_units;
  logic        grp_load;
  logic        grp_done;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pointer_sequencer #(.N_UNITS(4), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_ksize(cfg_ksize),
    .cfg_n_out(cfg_n_out), .ready(ready), .step(step), .start_addr(start_addr),
    .kernel_size(kernel_size), .active_units(active_units), .grp_load(grp_load),
    .grp_done(grp_done), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job from a start pulse to its done pulse and checks the observed trace.
  task automatic run_job(input string tag, input logic [15:0] base, input logic [7:0] k,
                         input logic [7:0] n, input bit toggle_rdy, input bit spam,
                         input int exp_done_at, input int exp_groups, input int exp_taps,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                         input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2);
    int steps = 0, loads = 0, gdones = 0, dones = 0, done_at = -1;
    int first_load = -1, first_step = -1, grp_steps = 0, last_step = -1;
    int bad_grp = 0, bad_gap = 0, bad_rdy = 0, bad_excl = 0, bad_ks = 0, bad_busy = 0;
    logic [15:0] la [3];
    logic [3:0]  lm [3];
    @(negedge clk);
    cfg_base = base; cfg_ksize = k; cfg_n_out = n;
    start = 1'b1;
    ready = 1'b1;
    for (int i = 1; i < 400 && done_at < 0; i++) begin
      @(negedge clk);
      start = spam && (i % 5 == 2);
      ready = toggle_rdy ? (i % 4 == 0 || i % 4 == 3) : 1'b1;
      #1;
      if (int'(step) + int'(grp_load) + int'(grp_done) + int'(done) > 1) bad_excl++;
      if (!busy) bad_busy++;
      if (grp_load) begin
        if (loads < 3) begin la[loads] = start_addr; lm[loads] = active_units; end
        if (first_load < 0) first_load = i;
        if (kernel_size !== k) bad_ks++;
        loads++;
        grp_steps = 0;
      end
      if (step) begin
        steps++; grp_steps++; last_step = i;
        if (first_step < 0) first_step = i;
        if (!ready) bad_rdy++;
      end
      if (grp_done) begin
        gdones++;
        if (grp_steps != exp_taps) bad_grp++;
        if (i - last_step != 2) bad_gap++;
      end
      if (done) begin dones++; done_at = i; end
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, " timeout"}, 32'(done_at >= 0), 32'd1);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " done_after"}, 32'(done), 32'd0);
    if (exp_done_at >= 0) chk({tag, " done_latency"}, 32'(done_at), 32'(exp_done_at));
    chk({tag, " grp_loads"}, 32'(loads), 32'(exp_groups));
    chk({tag, " grp_dones"}, 32'(gdones), 32'(exp_groups));
    chk({tag, " steps"}, 32'(steps), 32'(exp_groups * exp_taps));
    chk({tag, " dones"}, 32'(dones), 32'd1);
    chk({tag, " excl"}, 32'(bad_excl), 32'd0);
    chk({tag, " busy"}, 32'(bad_busy), 32'd0);
    chk({tag, " steps_per_grp"}, 32'(bad_grp), 32'd0);
    chk({tag, " drain_gap"}, 32'(bad_gap), 32'd0);
    chk({tag, " step_wo_ready"}, 32'(bad_rdy), 32'd0);
    chk({tag, " kernel_size"}, 32'(bad_ks), 32'd0);
    if (exp_groups > 0) begin
      chk({tag, " first_load"}, 32'(first_load), 32'd1);
      chk({tag, " addr0"}, 32'(la[0]), 32'(a0));
      chk({tag, " mask0"}, 32'(lm[0]), 32'(m0));
      if (!toggle_rdy) chk({tag, " first_step"}, 32'(first_step), 32'd2);
    end
    if (exp_groups > 1) begin
      chk({tag, " addr1"}, 32'(la[1]), 32'(a1));
      chk({tag, " mask1"}, 32'(lm[1]), 32'(m1));
    end
    if (exp_groups > 2) begin
      chk({tag, " addr2"}, 32'(la[2]), 32'(a2));
      chk({tag, " mask2"}, 32'(lm[2]), 32'(m2));
    end
    $display("job %s: groups=%0d steps=%0d done_at=%0d", tag, loads, steps, done_at);
  endtask

  initial begin
    int loads_seen;
    int dones_seen;
    int busy_seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset outs", {step, grp_load, grp_done, done, busy}, 32'd0);
    chk("reset addr", 32'(start_addr), 32'd0);
    chk("reset ks", 32'(kernel_size), 32'd0);
    chk("reset mask", 32'(active_units), 32'd0);
    rst = 1'b1;

    // 1 group, 9 taps: done on cycle 1+1+9+2 after start.
    run_job("single", 16'd100, 8'd3, 8'd3, 1'b0, 1'b0, 13, 1, 9,
            16'd100, 16'd0, 16'd0, 4'b0111, 4'b0, 4'b0);
    // 3 groups, stride 36.
    run_job("three", 16'd100, 8'd3, 8'd10, 1'b0, 1'b0, 37, 3, 9,
            16'd100, 16'd136, 16'd172, 4'b1111, 4'b1111, 4'b0011);
    // K=2 with ready pattern 1,0,0,1.
    run_job("backpr", 16'h0200, 8'd2, 8'd5, 1'b1, 1'b0, -1, 2, 4,
            16'h0200, 16'h0210, 16'd0, 4'b1111, 4'b0001, 4'b0);
    // Zero-sized jobs.
    run_job("nout0", 16'd50, 8'd3, 8'd0, 1'b0, 1'b0, 1, 0, 0,
            16'd0, 16'd0, 16'd0, 4'b0, 4'b0, 4'b0);
    run_job("k0", 16'd50, 8'd0, 8'd7, 1'b0, 1'b0, 1, 0, 0,
            16'd0, 16'd0, 16'd0, 4'b0, 4'b0, 4'b0);
    // Address wrap, with start pulses while busy.
    run_job("wrap", 16'hFFF0, 8'd4, 8'd8, 1'b0, 1'b1, 39, 2, 16,
            16'hFFF0, 16'h0030, 16'd0, 4'b1111, 4'b1111, 4'b0);

    // Reset in the middle of group 2 RUN.
    @(negedge clk);
    cfg_base = 16'd100; cfg_ksize = 8'd3; cfg_n_out = 8'd10;
    start = 1'b1; ready = 1'b1;
    loads_seen = 0;
    for (int i = 0; i < 100 && loads_seen < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (grp_load) loads_seen++;
    end
    chk("rst reached grp2", 32'(loads_seen), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("rst pre step", 32'(step), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst outs", {step, grp_load, grp_done, done, busy}, 32'd0);
    chk("rst addr", 32'(start_addr), 32'd0);
    chk("rst mask", 32'(active_units), 32'd0);
    rst = 1'b1;
    dones_seen = 0; busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (done) dones_seen++;
      if (busy) busy_seen++;
    end
    chk("rst no done", 32'(dones_seen), 32'd0);
    chk("rst stays idle", 32'(busy_seen), 32'd0);
    $display("reset abort: dones=%0d busy_cycles=%0d", dones_seen, busy_seen);
    run_job("after_rst", 16'd100, 8'd3, 8'd10, 1'b0, 1'b0, 37, 3, 9,
            16'd100, 16'd136, 16'd172, 4'b1111, 4'b1111, 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
